// File: rtl/booth_ctrl_if.sv
// Handshake and datapath-control bundle between booth_ctrl and its neighbours.
// master = upstream requester plus datapath; slave = the controller itself.
interface booth_ctrl_if;
    logic       start;
    logic [2:0] cmp0;
    logic [2:0] cmp1;
    logic       load;
    logic       muxsel;
    logic [2:0] ALUop;
    logic       shift_direction;
    logic [2:0] Tshift_amount;
    logic [2:0] shift_amount;
    logic       out_enable;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output start, cmp0, cmp1,
        input  load, muxsel, ALUop, shift_direction, Tshift_amount,
               shift_amount, out_enable, busy, done, err
    );

    modport slave (
        input  start, cmp0, cmp1,
        output load, muxsel, ALUop, shift_direction, Tshift_amount,
               shift_amount, out_enable, busy, done, err
    );
endinterface

// File: rtl/booth_ctrl.sv
// Sequencer for the radix-4 Booth 8x4 multiplier: clear, two accumulate steps, then present.
// Every control output is registered and is updated on the same edge as the state it belongs to.
module booth_ctrl #(
    parameter int unsigned DONE_CYCLES = 1
) (
    input  logic         clk,
    input  logic         rst,
    booth_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_STEP0,
        S_STEP1,
        S_DONE
    } state_t;

    state_t     r_state;
    logic [2:0] r_d0;
    logic [2:0] r_d1;
    logic       r_err;
    logic [2:0] r_doneCnt;
    logic       r_load;
    logic       r_muxsel;
    logic [2:0] r_aluOp;
    logic [2:0] r_tShift;
    logic       r_outEnable;
    logic       r_busy;
    logic       r_done;

    // Packs {muxsel, ALUop, Tshift}; an illegal magnitude of 3 behaves like a zero digit.
    function automatic logic [6:0] stepCtrl(input logic [2:0] digit, input logic k);
        logic [1:0] mag;
        logic       isZero;
        mag    = digit[1:0];
        isZero = (mag == 2'd0) || (mag == 2'd3);
        stepCtrl = {isZero,
                    isZero ? 3'b000 : (digit[2] ? 3'b010 : 3'b001),
                    1'b0, k, (mag == 2'd2)};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_d0        <= 3'b000;
            r_d1        <= 3'b000;
            r_err       <= 1'b0;
            r_doneCnt   <= 3'd0;
            r_load      <= 1'b0;
            r_muxsel    <= 1'b1;
            r_aluOp     <= 3'b000;
            r_tShift    <= 3'd0;
            r_outEnable <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_d0     <= bus.cmp0;
                        r_d1     <= bus.cmp1;
                        r_err    <= (bus.cmp0[1:0] == 2'd3) || (bus.cmp1[1:0] == 2'd3);
                        r_state  <= S_CLR;
                        r_load   <= 1'b1;
                        r_muxsel <= 1'b1;
                        r_aluOp  <= 3'b011;
                        r_tShift <= 3'd0;
                        r_busy   <= 1'b1;
                    end
                end
                S_CLR: begin
                    r_state <= S_STEP0;
                    {r_muxsel, r_aluOp, r_tShift} <= stepCtrl(r_d0, 1'b0);
                end
                S_STEP0: begin
                    r_state <= S_STEP1;
                    {r_muxsel, r_aluOp, r_tShift} <= stepCtrl(r_d1, 1'b1);
                end
                S_STEP1: begin
                    r_state     <= S_DONE;
                    r_load      <= 1'b0;
                    r_muxsel    <= 1'b1;
                    r_aluOp     <= 3'b000;
                    r_tShift    <= 3'd0;
                    r_outEnable <= 1'b1;
                    r_done      <= 1'b1;
                    r_doneCnt   <= 3'd0;
                end
                S_DONE: begin
                    if (r_doneCnt == 3'(DONE_CYCLES - 1)) begin
                        r_state     <= S_IDLE;
                        r_doneCnt   <= 3'd0;
                        r_outEnable <= 1'b0;
                        r_done      <= 1'b0;
                        r_busy      <= 1'b0;
                    end else begin
                        r_doneCnt <= r_doneCnt + 3'd1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_load      <= 1'b0;
                    r_muxsel    <= 1'b1;
                    r_aluOp     <= 3'b000;
                    r_tShift    <= 3'd0;
                    r_outEnable <= 1'b0;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.load            = r_load;
    assign bus.muxsel          = r_muxsel;
    assign bus.ALUop           = r_aluOp;
    assign bus.shift_direction = 1'b0;
    assign bus.Tshift_amount   = r_tShift;
    assign bus.shift_amount    = 3'd0;
    assign bus.out_enable      = r_outEnable;
    assign bus.busy            = r_busy;
    assign bus.done            = r_done;
    assign bus.err             = r_err;

endmodule

// File: tb/tb_booth_ctrl.sv
// Bench for booth_ctrl: a simple product-register datapath follows the controls,
// and each product is compared against the signed multiply M*Q.
module tb_booth_ctrl;

    localparam int DC = 2;

    logic clk;
    logic rst;
    int   testsRun;
    int   failCount;

    logic signed [7:0]  mcand;
    logic signed [15:0] pReg;
    logic signed [15:0] aVal;

    booth_ctrl_if bus();

    booth_ctrl #(.DONE_CYCLES(DC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Product register of the neighbouring datapath, driven only by the controller's outputs.
    always @(posedge clk) begin
        aVal = bus.muxsel ? 16'sd0 : (16'(mcand) <<< bus.Tshift_amount);
        if (bus.load) begin
            case (bus.ALUop)
                3'b001:  pReg <= pReg + aVal;
                3'b010:  pReg <= pReg - aVal;
                3'b011:  pReg <= aVal;
                default: pReg <= pReg;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            failCount++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkIdle(input string tag, input bit expErr);
        checkOutput({tag, ".load"},   16'(bus.load), 16'd0);
        checkOutput({tag, ".muxsel"}, 16'(bus.muxsel), 16'd1);
        checkOutput({tag, ".aluop"},  16'(bus.ALUop), 16'd0);
        checkOutput({tag, ".oe"},     16'(bus.out_enable), 16'd0);
        checkOutput({tag, ".busy"},   16'(bus.busy), 16'd0);
        checkOutput({tag, ".done"},   16'(bus.done), 16'd0);
        checkOutput({tag, ".err"},    16'(bus.err), 16'(expErr));
    endtask

    task automatic checkStep(input string tag, input int d, input int k, input bit expErr);
        int expAlu;
        int expShift;
        expAlu   = (d == 0) ? 0 : ((d < 0) ? 2 : 1);
        expShift = 2 * k + ((d == 2 || d == -2) ? 1 : 0);
        checkOutput({tag, ".load"},   16'(bus.load), 16'd1);
        checkOutput({tag, ".muxsel"}, 16'(bus.muxsel), (d == 0) ? 16'd1 : 16'd0);
        checkOutput({tag, ".aluop"},  16'(bus.ALUop), 16'(expAlu));
        checkOutput({tag, ".tshift"}, 16'(bus.Tshift_amount), 16'(expShift));
        checkOutput({tag, ".sdir"},   16'(bus.shift_direction), 16'd0);
        checkOutput({tag, ".samt"},   16'(bus.shift_amount), 16'd0);
        checkOutput({tag, ".busy"},   16'(bus.busy), 16'd1);
        checkOutput({tag, ".done"},   16'(bus.done), 16'd0);
        checkOutput({tag, ".err"},    16'(bus.err), 16'(expErr));
    endtask

    // Booth digits are recomputed from Q as signed integers; the product is plain M*Q.
    task automatic applyStimulus(input logic signed [7:0] m, input logic signed [3:0] q,
                                 input bit illegal0, input bit holdStart,
                                 input bit pulseStep0, input bit resetStep1);
        int d0;
        int d1;
        int expProd;
        logic [2:0] c0;
        logic [2:0] c1;
        logic [7:0] expLow;
        bit expErr;
        d0 = -2 * int'(q[1]) + int'(q[0]);
        d1 = -2 * int'(q[3]) + int'(q[2]) + int'(q[1]);
        c0 = {(d0 < 0), 2'((d0 < 0) ? -d0 : d0)};
        c1 = {(d1 < 0), 2'((d1 < 0) ? -d1 : d1)};
        if (illegal0) begin
            c0 = 3'b011;
            d0 = 0;
        end
        expErr  = illegal0;
        expProd = illegal0 ? int'(m) * 4 * d1 : int'(m) * int'(q);
        expLow  = 8'(expProd);

        mcand    = m;
        bus.cmp0 = c0;
        bus.cmp1 = c1;
        bus.start = 1'b1;
        tick();
        if (!holdStart) bus.start = 1'b0;
        bus.cmp0 = 3'($urandom);
        bus.cmp1 = 3'($urandom);

        checkOutput("clr.load",   16'(bus.load), 16'd1);
        checkOutput("clr.muxsel", 16'(bus.muxsel), 16'd1);
        checkOutput("clr.aluop",  16'(bus.ALUop), 16'd3);
        checkOutput("clr.busy",   16'(bus.busy), 16'd1);
        checkOutput("clr.done",   16'(bus.done), 16'd0);
        checkOutput("clr.err",    16'(bus.err), 16'(expErr));

        tick();
        checkStep("step0", d0, 0, expErr);
        if (pulseStep0) bus.start = 1'b1;
        tick();
        if (pulseStep0) bus.start = 1'b0;
        checkStep("step1", d1, 1, expErr);

        if (resetStep1) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
            checkIdle("rst", 1'b0);
            return;
        end

        for (int i = 0; i < DC; i++) begin
            tick();
            checkOutput("done.done", 16'(bus.done), 16'd1);
            checkOutput("done.oe",   16'(bus.out_enable), 16'd1);
            checkOutput("done.busy", 16'(bus.busy), 16'd1);
            checkOutput("done.load", 16'(bus.load), 16'd0);
            checkOutput("done.aluop", 16'(bus.ALUop), 16'd0);
            checkOutput("done.prod", 16'(pReg[7:0]), 16'(expLow));
            checkOutput("done.err",  16'(bus.err), 16'(expErr));
        end
        tick();
        checkIdle("idle", expErr);
        if (pulseStep0) begin
            tick();
            checkIdle("noretrig", expErr);
        end
    endtask

    initial begin
        testsRun  = 0;
        failCount = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.cmp0  = 3'b000;
        bus.cmp1  = 3'b000;
        mcand     = 8'sd0;
        pReg      = 16'sd0;
        tick();
        tick();
        checkIdle("reset", 1'b0);
        checkOutput("reset.tshift", 16'(bus.Tshift_amount), 16'd0);
        rst = 1'b0;
        tick();

        applyStimulus(8'sd5,    4'sd6,  1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(-8'sd7,   -4'sd1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'sd127,  -4'sd8, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'sd9,    4'sd5,  1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(-8'sd3,   4'sd7,  1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'sd11,   -4'sd3, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(8'sd13,   4'sd3,  1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(-8'sd128, 4'sd7,  1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            logic signed [7:0] m;
            logic signed [3:0] q;
            m = 8'($urandom);
            q = 4'($urandom);
            applyStimulus(m, q, 1'b0, i[0], 1'b0, 1'b0);
        end
        bus.start = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
